// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter for the register file: one registered write per cycle,
// one-hot enables, drop reporting and pending-write forwarding. Optional ZERO_REG_PROTECT_EN.
module reg_write_arbiter #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int NUM_CH   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        req_valid,
   output logic [NUM_CH-1:0]        req_ready,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*DATA_W-1:0] req_data,
   input  logic                     hold,
   output logic [NUM_REGS-1:0]      reg_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic                     drop_err,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic                     fwd_hit,
   output logic [DATA_W-1:0]        fwd_data
);
   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

   logic              valid_q, drop_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [PTR_W-1:0]  ptr;

   logic              grant_any;
   logic [PTR_W-1:0]  grant_idx, ptr_next;
   logic [ADDR_W-1:0] grant_addr;
   logic [DATA_W-1:0] grant_data;
   logic              grant_drop;
   logic              live;
   int                ch;

   // Search starts at ptr and wraps; first valid channel wins.
   always_comb begin
      req_ready = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      ch        = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch = int'(ptr) + i;
         if (ch >= NUM_CH) ch = ch - NUM_CH;
         if (!hold && !grant_any && req_valid[ch]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(ch);
         end
      end
      if (grant_any) req_ready[grant_idx] = 1'b1;
   end

   assign grant_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
   assign grant_data = req_data[grant_idx*DATA_W +: DATA_W];
   assign ptr_next   = (grant_idx == PTR_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;

`ifdef ZERO_REG_PROTECT_EN
   assign grant_drop = ({1'b0, grant_addr} >= REG_LIMIT) || (grant_addr == '0);
`else
   assign grant_drop = ({1'b0, grant_addr} >= REG_LIMIT);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         drop_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         ptr     <= '0;
      end else if (!hold) begin
         valid_q <= grant_any;
         if (grant_any) begin
            addr_q <= grant_addr;
            data_q <= grant_data;
            drop_q <= grant_drop;
            ptr    <= ptr_next;
         end
      end
   end

   assign live = valid_q & ~drop_q;

   // Enables only ever come from registered state, never from req_valid directly.
   always_comb begin
      reg_en = '0;
      for (int k = 0; k < NUM_REGS; k++)
         reg_en[k] = live & ~hold & (addr_q == ADDR_W'(k));
   end

   assign drop_err = valid_q & drop_q & ~hold;
   assign wr_addr  = addr_q;
   assign wr_data  = data_q;

`ifdef ZERO_REG_PROTECT_EN
   assign fwd_hit  = live & (addr_q == rd_addr) & (rd_addr != '0);
`else
   assign fwd_hit  = live & (addr_q == rd_addr);
`endif
   assign fwd_data = fwd_hit ? data_q : '0;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed plus random bench for reg_write_arbiter (NUM_REGS=24, NUM_CH=2) against a
// behavioural model of the pending write and round-robin order.
module tb_reg_write_arbiter;
   localparam int NUM_REGS = 24;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_CH   = 2;
`ifdef ZERO_REG_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_CH-1:0]        req_valid;
   logic [NUM_CH-1:0]        req_ready;
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH*DATA_W-1:0] req_data;
   logic                     hold;
   logic [NUM_REGS-1:0]      reg_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     drop_err;
   logic [ADDR_W-1:0]        rd_addr;
   logic                     fwd_hit;
   logic [DATA_W-1:0]        fwd_data;

   int n_assert = 0;
   int n_fail   = 0;

   // model of the pending write
   bit          m_valid, m_drop;
   int          m_addr, m_ptr;
   logic [31:0] m_data;

   reg_write_arbiter #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .hold(hold), .reg_en(reg_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .drop_err(drop_err), .rd_addr(rd_addr),
      .fwd_hit(fwd_hit), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_drop = 0; m_addr = 0; m_data = '0; m_ptr = 0;
   endtask

   task automatic set_req(input int c, input logic v, input int a, input logic [31:0] d);
      req_valid[c] = v;
      req_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(a);
      req_data[c*DATA_W +: DATA_W] = d;
   endtask

   task automatic idle();
      req_valid = '0;
   endtask

   // Check combinational outputs mid-cycle, then advance the model across the edge.
   task automatic cycle();
      int win;
      logic [NUM_CH-1:0]   exp_ready;
      logic [NUM_REGS-1:0] exp_en;
      bit                  exp_hit;
      @(negedge clk);
      win = -1;
      if (!hold)
         for (int i = 0; i < NUM_CH; i++) begin
            int c = (m_ptr + i) % NUM_CH;
            if (win < 0 && req_valid[c]) win = c;
         end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      exp_en = '0;
      if (m_valid && !m_drop && !hold) exp_en[m_addr] = 1'b1;
      exp_hit = m_valid && !m_drop && (m_addr == int'(rd_addr)) && !(PROT && rd_addr == 0);
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("reg_en",    64'(reg_en),    64'(exp_en));
      check("wr_addr",   64'(wr_addr),   64'(m_addr));
      check("wr_data",   64'(wr_data),   64'(m_data));
      check("drop_err",  64'(drop_err),  64'(m_valid && m_drop && !hold));
      check("fwd_hit",   64'(fwd_hit),   64'(exp_hit));
      check("fwd_data",  64'(fwd_data),  exp_hit ? 64'(m_data) : 64'(0));
      @(posedge clk);
      if (rst_n && !hold) begin
         m_valid = (win >= 0);
         if (win >= 0) begin
            m_addr = int'(req_addr[win*ADDR_W +: ADDR_W]);
            m_data = req_data[win*DATA_W +: DATA_W];
            m_drop = (m_addr >= NUM_REGS) || (PROT && m_addr == 0);
            m_ptr  = (win + 1) % NUM_CH;
         end
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; hold = 1'b0; rd_addr = '0;
      model_reset();
      // reset, idle
      repeat (3) cycle();
      @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;

      // single write ch0 addr 5
      set_req(0, 1'b1, 5, 32'hDEADBEEF); rd_addr = 5;
      cycle();
      idle(); cycle();
      cycle();

      // contention: alternating grants
      set_req(0, 1'b1, 3, 32'h33); set_req(1, 1'b1, 7, 32'h77);
      repeat (5) cycle();
      idle(); cycle();

      // hold with pending write
      set_req(0, 1'b1, 20, 32'hCAFE0020); rd_addr = 20;
      cycle();
      idle(); hold = 1'b1;
      repeat (4) cycle();
      hold = 1'b0; cycle();
      cycle();

      // out-of-range and zero address
      set_req(1, 1'b1, 30, 32'h30303030); rd_addr = 30;
      cycle(); idle(); cycle();
      set_req(0, 1'b1, 0, 32'h00000AAA); rd_addr = 0;
      cycle(); idle(); cycle();
      cycle();

      // reset right after accepting a write to 9
      set_req(1, 1'b1, 9, 32'h99); rd_addr = 9;
      cycle();
      idle(); rst_n = 1'b0; model_reset();
      repeat (2) cycle();
      @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;
      set_req(0, 1'b1, 3, 32'h13); set_req(1, 1'b1, 7, 32'h17);
      repeat (3) cycle();
      idle(); cycle();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < NUM_CH; c++)
            set_req(c, $urandom_range(0, 2) != 0, $urandom_range(0, 31), $urandom);
         hold    = ($urandom_range(0, 4) == 0);
         rd_addr = $urandom_range(0, 1) ? ADDR_W'(m_addr) : ADDR_W'($urandom_range(0, 31));
         cycle();
      end
      idle(); hold = 1'b0; cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
